// File: rtl/seq_alu_if.sv
// Handshake and data bundle between the control unit and the sequential ALU.
// The master side issues Start/Control/operands; the slave side returns results and status.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       control;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;
    logic             divzero;
    logic             busy;
    logic             done;

    modport master (
        output start, control, input1, input2,
        input  out, hi, zero, overflow, divzero, busy, done
    );

    modport slave (
        input  start, control, input1, input2,
        output out, hi, zero, overflow, divzero, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MULTU (shift-add)
// and DIVU (restoring divide) that take WIDTH steps and write Hi/Lo.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    seq_alu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MULTU = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_SLTU  = 4'd13;

    typedef enum logic {S_IDLE, S_ITER} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic [WIDTH-1:0] acc_q;     // partial product high half / partial remainder
    logic [WIDTH-1:0] lo_q;      // multiplier bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] opnd_q;    // latched multiplicand or divisor
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] hi_q;
    logic             zero_q;
    logic             ovf_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] single_res_d;
    logic             single_ovf_d;
    logic [WIDTH:0]   mul_sum_d;
    logic [WIDTH:0]   div_diff_d;
    logic [WIDTH-1:0] step_acc_d;
    logic [WIDTH-1:0] step_lo_d;

    function automatic logic [WIDTH-1:0] alu_result(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_ADD:  alu_result = a + b;
            OP_SUB:  alu_result = a - b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_NOR:  alu_result = ~(a | b);
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_result = '0;
        endcase
    endfunction

    // Overflow flags only ADD/SUB: result sign disagrees with A when the
    // effective operand signs agree.
    function automatic logic add_sub_ovf(input logic [3:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] r);
        logic sign_a;
        logic sign_b;
        logic sign_r;
        sign_a = a[WIDTH-1];
        sign_b = b[WIDTH-1];
        sign_r = r[WIDTH-1];
        if (op == OP_ADD)
            add_sub_ovf = (sign_a == sign_b) && (sign_r != sign_a);
        else if (op == OP_SUB)
            add_sub_ovf = (sign_a != sign_b) && (sign_r != sign_a);
        else
            add_sub_ovf = 1'b0;
    endfunction

    // Single-cycle result from live inputs, and one iteration step of MULTU/DIVU.
    always_comb begin
        single_res_d = alu_result(bus.control, bus.input1, bus.input2);
        single_ovf_d = add_sub_ovf(bus.control, bus.input1, bus.input2, single_res_d);
        mul_sum_d    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_diff_d   = {acc_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
        if (is_div_q) begin
            step_acc_d = div_diff_d[WIDTH] ? {acc_q[WIDTH-2:0], lo_q[WIDTH-1]}
                                           : div_diff_d[WIDTH-1:0];
            step_lo_d  = {lo_q[WIDTH-2:0], ~div_diff_d[WIDTH]};
        end else begin
            step_acc_d = mul_sum_d[WIDTH:1];
            step_lo_d  = {mul_sum_d[0], lo_q[WIDTH-1:1]};
        end
    end

    // Control FSM with registered results; last iteration step writes Hi/Lo directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.control == OP_MULTU) begin
                            acc_q    <= '0;
                            lo_q     <= bus.input2;
                            opnd_q   <= bus.input1;
                            is_div_q <= 1'b0;
                            cnt_q    <= CW'(WIDTH);
                            busy_q   <= 1'b1;
                            state_q  <= S_ITER;
                        end else if (bus.control == OP_DIVU && bus.input2 != '0) begin
                            acc_q    <= '0;
                            lo_q     <= bus.input1;
                            opnd_q   <= bus.input2;
                            is_div_q <= 1'b1;
                            cnt_q    <= CW'(WIDTH);
                            busy_q   <= 1'b1;
                            state_q  <= S_ITER;
                        end else if (bus.control == OP_DIVU) begin
                            out_q  <= '1;
                            hi_q   <= bus.input1;
                            zero_q <= 1'b0;
                            ovf_q  <= 1'b0;
                            dz_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            out_q  <= single_res_d;
                            zero_q <= (single_res_d == '0);
                            ovf_q  <= single_ovf_d;
                            dz_q   <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    acc_q <= step_acc_d;
                    lo_q  <= step_lo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= step_lo_d;
                        hi_q    <= step_acc_d;
                        zero_q  <= (step_lo_d == '0);
                        ovf_q   <= 1'b0;
                        dz_q    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out      = out_q;
    assign bus.hi       = hi_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.divzero  = dz_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes model results, a monitor pops on Done.
module tb_seq_alu;
    localparam int W = 32;
    localparam longint MAXS = 2147483647;
    localparam longint MINS = -MAXS - 1;

    typedef struct packed {
        logic [31:0] out;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_hi;
    logic [3:0]  sops [14] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13,
                               4'd3, 4'd4, 4'd5, 4'd10, 4'd11, 4'd14, 4'd15};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference behaviour from the op definitions, using wide plain arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] hi_prev);
        exp_t            e;
        longint          s;
        longint unsigned p;
        int              sa;
        int              sb;
        sa = a;
        sb = b;
        e.hi = hi_prev;
        e.out = '0;
        e.ovf = 1'b0;
        e.dz = 1'b0;
        case (op)
            4'd0:  e.out = a & b;
            4'd1:  e.out = a | b;
            4'd2:  begin
                e.out = a + b;
                s = longint'(sa) + longint'(sb);
                e.ovf = (s > MAXS) || (s < MINS);
            end
            4'd6:  begin
                e.out = a - b;
                s = longint'(sa) - longint'(sb);
                e.ovf = (s > MAXS) || (s < MINS);
            end
            4'd7:  e.out = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: e.out = ~(a | b);
            4'd13: e.out = (a < b) ? 32'd1 : 32'd0;
            4'd8:  begin
                p = {32'd0, a} * {32'd0, b};
                e.out = p[31:0];
                e.hi = p[63:32];
            end
            4'd9:  begin
                if (b == 0) begin
                    e.out = 32'hFFFF_FFFF;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    e.out = a / b;
                    e.hi = a % b;
                end
            end
            default: e.out = '0;
        endcase
        e.zero = (e.out == 0);
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: actual=done required=no done");
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {bus.out, bus.hi, bus.zero, bus.overflow, bus.divzero}, mon_e);
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.control = op;
        bus.input1  = a;
        bus.input2  = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state",
              {bus.out, bus.hi, bus.zero, bus.overflow, bus.divzero, bus.busy, bus.done},
              {32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        exp_q.delete();
        model_hi = '0;
    endtask

    // Issue one op, scramble operands after the Start edge, optionally poke Start while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        exp_t e;
        int   lat;
        int   busy_n;
        bit   iter;
        iter = (op == 4'd8) || (op == 4'd9 && b != 0);
        e = model(op, a, b, model_hi);
        model_hi = e.hi;
        exp_q.push_back(e);
        drive(op, a, b);
        bus.start = 1'b1;
        lat = 0;
        busy_n = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = 1'b0;
            bus.input1 = $urandom;
            bus.input2 = $urandom;
            if (inject && lat == 5) begin
                bus.start = 1'b1;
                bus.control = 4'd0;
            end
            if (bus.busy === 1'b1) busy_n++;
        end while (bus.done !== 1'b1 && lat < W + 8);
        check($sformatf("latency_op%0d", op), lat, iter ? W + 1 : 1);
        check($sformatf("busy_cycles_op%0d", op), busy_n, iter ? W : 0);
    endtask

    // Start held high: a new single-cycle op (or DIVU by zero) every cycle.
    task automatic burst(input int n);
        exp_t       e;
        logic [3:0] op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < n; i++) begin
            a = rnd_val();
            b = rnd_val();
            if ($urandom_range(0, 5) == 0) begin
                op = 4'd9;
                b = 32'h0;
            end else begin
                op = sops[$urandom_range(0, 13)];
            end
            e = model(op, a, b, model_hi);
            model_hi = e.hi;
            exp_q.push_back(e);
            drive(op, a, b);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            check("b2b_done_busy", {bus.done, bus.busy}, 2'b10);
        end
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bus.start = 1'b0;
        drive(4'd0, 32'h0, 32'h0);
        rst = 1'b1;
        model_hi = '0;
        @(posedge clk);
        #1;
        do_reset();

        run_op(4'd2, 32'h7FFF_FFFF, 32'h1, 1'b0);
        run_op(4'd6, 32'd5, 32'd5, 1'b0);
        run_op(4'd7, 32'hFFFF_FFFF, 32'h1, 1'b0);
        run_op(4'd13, 32'hFFFF_FFFF, 32'h1, 1'b0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'h2, 1'b0);
        run_op(4'd9, 32'd100, 32'd7, 1'b1);
        run_op(4'd9, 32'd9, 32'd0, 1'b0);

        // Reset during the tenth MULTU iteration: op abandoned, no Done afterwards.
        drive(4'd8, 32'hFFFF_FFFF, 32'h1234_5678);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        check("no_resume_after_reset", {bus.busy, bus.done}, 2'b00);

        burst(10);

        repeat (60) begin
            op = 4'($urandom_range(0, 15));
            a = rnd_val();
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_val();
            run_op(op, a, b, ($urandom_range(0, 3) == 0));
        end

        burst(10);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
